// File: rtl/rtc_pkg.sv
// Shared types and constants for the DS1302 access scheduler.
package rtc_pkg;

    // Clock-halt flag position inside the seconds byte.
    localparam int CH_BIT = 7;

    // BCD time as {hour, minute, second}.
    typedef logic [23:0] bcd_time_t;

    typedef enum logic [2:0] {
        ST_INIT_RD = 3'd0,
        ST_INIT_WR = 3'd1,
        ST_IDLE    = 3'd2,
        ST_RD      = 3'd3,
        ST_WR      = 3'd4
    } rtc_state_t;

    // Counter width able to hold n-1; never below one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Force CH low so a write never halts the oscillator.
    function automatic bcd_time_t clear_ch(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        r[CH_BIT] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/rtc_req_timer.sv
// Loadable down-counter; expire is high while enabled and the count sits at zero.
module rtc_req_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over counting; the count parks at zero until reloaded.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = en && (count_q == '0);

endmodule

// File: rtl/rtc_access_sched.sv
// Schedules reads/writes to a DS1302 driver: boot check of the CH flag,
// user set/clear writes and periodic time reads, with a request timeout.
// Optional macro RTC_POLL_TIMER_EN: pace reads with a POLL_DIV counter
// instead of reading on every free IDLE cycle.
module rtc_access_sched
    import rtc_pkg::*;
#(
    parameter int POLL_DIV    = 5000000,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_req,
    input  logic [23:0] set_time,
    input  logic        clr_req,
    output logic        rtc_wr_req,
    input  logic        rtc_wr_ack,
    output logic [23:0] rtc_wr_time,
    output logic        rtc_rd_req,
    input  logic        rtc_rd_ack,
    input  logic [7:0]  rtc_rd_sec,
    output logic        rd_done,
    output logic        init_done,
    output logic        busy,
    output logic        err
);

    localparam int            TO_W    = clog2_min1(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

    rtc_state_t state_q, state_d;
    logic       rd_req_q, rd_req_d;
    logic       wr_req_q, wr_req_d;
    bcd_time_t  wr_time_q, wr_time_d;
    bcd_time_t  set_time_q, set_time_d;
    logic       set_pend_q, set_pend_d;
    logic       clr_pend_q, clr_pend_d;
    logic       set_rearm_q, set_rearm_d;
    logic       wr_is_clr_q, wr_is_clr_d;
    logic       init_done_q, init_done_d;
    logic       rd_done_q, rd_done_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;

    logic       to_load, to_expire;
    logic       poll_restart, poll_due;
    logic       rd_acked, wr_acked;
    logic       wr_done_set, wr_done_clr;
    logic       unused_sec_bits;

    // Only the CH bit of the read-back seconds matters here.
    assign unused_sec_bits = ^rtc_rd_sec[6:0];

    assign rd_acked = rd_req_q & rtc_rd_ack;
    assign wr_acked = wr_req_q & rtc_wr_ack;

    rtc_req_timer #(.W(TO_W)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load     (to_load),
        .load_val (TO_LOAD),
        .en       (rd_req_q | wr_req_q),
        .expire   (to_expire)
    );

`ifdef RTC_POLL_TIMER_EN
    localparam int              POLL_W    = clog2_min1(POLL_DIV);
    localparam logic [POLL_W-1:0] POLL_LOAD = POLL_W'(POLL_DIV - 1);

    // Counts only IDLE cycles, so read spacing is POLL_DIV plus the read itself.
    rtc_req_timer #(.W(POLL_W)) u_poll (
        .clk      (clk),
        .rst      (rst),
        .load     (poll_restart),
        .load_val (POLL_LOAD),
        .en       (state_q == ST_IDLE),
        .expire   (poll_due)
    );
`else
    logic unused_poll;

    // No pacing: any free IDLE cycle issues a read.
    assign poll_due    = 1'b1;
    assign unused_poll = poll_restart & (POLL_DIV > 0);
`endif

    // Next-state and handshake logic; requests rise on state entry and
    // drop the cycle after ack or timeout.
    always_comb begin
        state_d      = state_q;
        rd_req_d     = rd_req_q;
        wr_req_d     = wr_req_q;
        wr_time_d    = wr_time_q;
        wr_is_clr_d  = wr_is_clr_q;
        init_done_d  = init_done_q;
        err_d        = err_q;
        rd_done_d    = 1'b0;
        to_load      = 1'b0;
        poll_restart = 1'b0;
        case (state_q)
            ST_INIT_RD: begin
                if (!rd_req_q) begin
                    // Entry after reset or after an init timeout.
                    rd_req_d = 1'b1;
                    to_load  = 1'b1;
                end else if (rd_acked) begin
                    rd_req_d  = 1'b0;
                    rd_done_d = 1'b1;
                    if (rtc_rd_sec[CH_BIT]) begin
                        state_d   = ST_INIT_WR;
                        wr_req_d  = 1'b1;
                        wr_time_d = '0;
                        to_load   = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end
                end else if (to_expire) begin
                    rd_req_d = 1'b0;
                    err_d    = 1'b1;
                end
            end
            ST_INIT_WR: begin
                if (wr_acked) begin
                    wr_req_d    = 1'b0;
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else if (to_expire) begin
                    wr_req_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ST_INIT_RD;
                end
            end
            ST_IDLE: begin
                if (init_done_q && clr_pend_q) begin
                    state_d     = ST_WR;
                    wr_req_d    = 1'b1;
                    wr_time_d   = '0;
                    wr_is_clr_d = 1'b1;
                    to_load     = 1'b1;
                end else if (init_done_q && set_pend_q) begin
                    state_d     = ST_WR;
                    wr_req_d    = 1'b1;
                    wr_time_d   = clear_ch(set_time_q);
                    wr_is_clr_d = 1'b0;
                    to_load     = 1'b1;
                end else if (poll_due) begin
                    state_d      = ST_RD;
                    rd_req_d     = 1'b1;
                    to_load      = 1'b1;
                    poll_restart = 1'b1;
                end
            end
            ST_RD: begin
                if (rd_acked) begin
                    state_d   = ST_IDLE;
                    rd_req_d  = 1'b0;
                    rd_done_d = 1'b1;
                end else if (to_expire) begin
                    state_d  = ST_IDLE;
                    rd_req_d = 1'b0;
                    err_d    = 1'b1;
                end
            end
            ST_WR: begin
                if (wr_acked) begin
                    state_d  = ST_IDLE;
                    wr_req_d = 1'b0;
                end else if (to_expire) begin
                    state_d  = ST_IDLE;
                    wr_req_d = 1'b0;
                    err_d    = 1'b1;
                end
            end
            default: begin
                state_d  = ST_INIT_RD;
                rd_req_d = 1'b0;
                wr_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Pending-request bookkeeping; a set arriving during its own write
    // re-arms the flag so the newer time is written afterwards.
    always_comb begin
        wr_done_set = (state_q == ST_WR) && wr_acked && !wr_is_clr_q;
        wr_done_clr = (state_q == ST_WR) && wr_acked && wr_is_clr_q;
        clr_pend_d  = clr_req | (clr_pend_q & ~wr_done_clr);
        set_pend_d  = (set_req | (set_pend_q & ~(wr_done_set & ~set_rearm_q))) & ~clr_pend_d;
        set_rearm_d = (state_d == ST_WR) && !wr_is_clr_d && (set_req || set_rearm_q);
        set_time_d  = set_req ? set_time : set_time_q;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT_RD;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_time_q   <= '0;
            set_time_q  <= '0;
            set_pend_q  <= 1'b0;
            clr_pend_q  <= 1'b0;
            set_rearm_q <= 1'b0;
            wr_is_clr_q <= 1'b0;
            init_done_q <= 1'b0;
            rd_done_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
            wr_time_q   <= wr_time_d;
            set_time_q  <= set_time_d;
            set_pend_q  <= set_pend_d;
            clr_pend_q  <= clr_pend_d;
            set_rearm_q <= set_rearm_d;
            wr_is_clr_q <= wr_is_clr_d;
            init_done_q <= init_done_d;
            rd_done_q   <= rd_done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign rtc_rd_req  = rd_req_q;
    assign rtc_wr_req  = wr_req_q;
    assign rtc_wr_time = wr_time_q;
    assign rd_done     = rd_done_q;
    assign init_done   = init_done_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_rtc_access_sched.sv
// Directed bench for rtc_access_sched: boot paths, set/clear scheduling,
// timeout, asynchronous reset and read pacing.
module tb_rtc_access_sched;

    localparam int POLL_DIV    = 10;
    localparam int TIMEOUT_CYC = 16;
`ifdef RTC_POLL_TIMER_EN
    localparam int EXP_GAP = POLL_DIV;
`else
    localparam int EXP_GAP = 1;
`endif

    logic        clk;
    logic        rst;
    logic        set_req;
    logic [23:0] set_time;
    logic        clr_req;
    logic        rtc_wr_req;
    logic        rtc_wr_ack;
    logic [23:0] rtc_wr_time;
    logic        rtc_rd_req;
    logic        rtc_rd_ack;
    logic [7:0]  rtc_rd_sec;
    logic        rd_done;
    logic        init_done;
    logic        busy;
    logic        err;

    int tests_run = 0;
    int fails     = 0;
    int n;
    int wr_seen;

    rtc_access_sched #(
        .POLL_DIV    (POLL_DIV),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .set_req     (set_req),
        .set_time    (set_time),
        .clr_req     (clr_req),
        .rtc_wr_req  (rtc_wr_req),
        .rtc_wr_ack  (rtc_wr_ack),
        .rtc_wr_time (rtc_wr_time),
        .rtc_rd_req  (rtc_rd_req),
        .rtc_rd_ack  (rtc_rd_ack),
        .rtc_rd_sec  (rtc_rd_sec),
        .rd_done     (rd_done),
        .init_done   (init_done),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance until a read request is up, at most max_cyc cycles.
    task automatic wait_rd(input int max_cyc, output int cyc);
        cyc = 0;
        while (rtc_rd_req !== 1'b1 && cyc < max_cyc) begin
            tick();
            cyc++;
        end
    endtask

    // Same, also counting cycles in which a write request is seen.
    task automatic watch_until_rd(input int max_cyc, output int wr_cnt);
        int cyc;
        wr_cnt = 0;
        cyc    = 0;
        while (rtc_rd_req !== 1'b1 && cyc < max_cyc) begin
            tick();
            cyc++;
            if (rtc_wr_req === 1'b1) wr_cnt++;
        end
    endtask

    initial begin
        rst        = 1'b1;
        set_req    = 1'b0;
        clr_req    = 1'b0;
        set_time   = 24'h0;
        rtc_wr_ack = 1'b0;
        rtc_rd_ack = 1'b0;
        rtc_rd_sec = 8'h80;

        // Reset state
        repeat (3) tick();
        chk("reset_busy", busy, 1);
        chk("reset_rd_req", rtc_rd_req, 0);
        chk("reset_wr_req", rtc_wr_req, 0);
        chk("reset_wr_time", rtc_wr_time, 0);
        chk("reset_init_done", init_done, 0);
        chk("reset_err", err, 0);
        chk("reset_rd_done", rd_done, 0);

        // Boot with CH=1: read, then clearing write
        rst = 1'b0;
        tick();
        chk("boot_rd_req", rtc_rd_req, 1);
        chk("boot_wr_req", rtc_wr_req, 0);
        rtc_rd_ack = 1'b1;
        tick();
        rtc_rd_ack = 1'b0;
        $display("[TB] boot read acked, seconds=0x80");
        chk("ch_rd_done", rd_done, 1);
        chk("ch_rd_req_drop", rtc_rd_req, 0);
        chk("ch_init_wr_req", rtc_wr_req, 1);
        chk("ch_init_wr_time", rtc_wr_time, 24'h000000);
        chk("ch_init_done_low", init_done, 0);
        rtc_wr_ack = 1'b1;
        tick();
        rtc_wr_ack = 1'b0;
        $display("[TB] boot write 00:00:00 acked");
        chk("ch_init_done", init_done, 1);
        chk("ch_wr_req_drop", rtc_wr_req, 0);
        chk("ch_idle_busy", busy, 0);
        chk("ch_rd_done_one_cycle", rd_done, 0);
        tick();
        chk("first_poll_rd_req", rtc_rd_req, 1);
        chk("first_poll_busy", busy, 1);

        // set_req during RD
        set_time = 24'h123456;
        set_req  = 1'b1;
        tick();
        set_req  = 1'b0;
        set_time = 24'h000000;
        chk("set_during_rd_req_held", rtc_rd_req, 1);
        rtc_rd_sec = 8'h15;
        rtc_rd_ack = 1'b1;
        tick();
        rtc_rd_ack = 1'b0;
        $display("[TB] read acked with set pending");
        chk("set_rd_done", rd_done, 1);
        chk("set_rd_req_drop", rtc_rd_req, 0);
        tick();
        chk("set_wr_req", rtc_wr_req, 1);
        chk("set_wr_time", rtc_wr_time, 24'h123456);
        chk("set_no_rd_during_wr", rtc_rd_req, 0);
        tick();
        chk("set_wr_time_stable", rtc_wr_time, 24'h123456);
        chk("set_wr_req_held", rtc_wr_req, 1);
        rtc_wr_ack = 1'b1;
        tick();
        rtc_wr_ack = 1'b0;
        $display("[TB] set write 12:34:56 acked");
        chk("set_wr_req_drop", rtc_wr_req, 0);
        watch_until_rd(20, wr_seen);
        chk("set_next_is_rd", rtc_rd_req, 1);
        chk("set_flag_cleared", wr_seen, 0);

        // clr_req and set_req together
        clr_req  = 1'b1;
        set_req  = 1'b1;
        set_time = 24'h654321;
        tick();
        clr_req  = 1'b0;
        set_req  = 1'b0;
        rtc_rd_ack = 1'b1;
        tick();
        rtc_rd_ack = 1'b0;
        tick();
        chk("clr_wr_req", rtc_wr_req, 1);
        chk("clr_wr_time", rtc_wr_time, 24'h000000);
        rtc_wr_ack = 1'b1;
        tick();
        rtc_wr_ack = 1'b0;
        $display("[TB] clear write acked");
        watch_until_rd(20, wr_seen);
        chk("clr_next_is_rd", rtc_rd_req, 1);
        chk("clr_no_set_write", wr_seen, 0);

        // Timeout with ack withheld
        chk("pre_timeout_err", err, 0);
        n = 0;
        while (rtc_rd_req === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        $display("[TB] read request dropped after %0d cycles", n);
        chk("timeout_req_cycles", n, TIMEOUT_CYC);
        chk("timeout_err", err, 1);
        chk("timeout_rd_req", rtc_rd_req, 0);
        chk("timeout_idle", busy, 0);

        // Reset mid-transaction, then boot with CH=0
        wait_rd(40, n);
        chk("pre_reset_rd_req", rtc_rd_req, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_rd_req", rtc_rd_req, 0);
        chk("async_rst_busy", busy, 1);
        chk("async_rst_err", err, 0);
        chk("async_rst_init_done", init_done, 0);
        rtc_rd_sec = 8'h15;
        tick();
        rst = 1'b0;
        wait_rd(5, n);
        chk("reboot_rd_req", rtc_rd_req, 1);
        chk("reboot_init_done_low", init_done, 0);
        rtc_rd_ack = 1'b1;
        tick();
        rtc_rd_ack = 1'b0;
        $display("[TB] reboot read acked, seconds=0x15");
        chk("noch_init_done", init_done, 1);
        chk("noch_rd_done", rd_done, 1);
        chk("noch_no_wr", rtc_wr_req, 0);
        chk("noch_idle", busy, 0);

        // Read pacing with 2-cycle acks
        wait_rd(40, n);
        chk("pace_rd1_req", rtc_rd_req, 1);
        tick();
        rtc_rd_ack = 1'b1;
        tick();
        rtc_rd_ack = 1'b0;
        chk("pace_rd1_done", rd_done, 1);
        wait_rd(40, n);
        $display("[TB] next read issued %0d cycles after rd_done", n);
        chk("pace_gap", n, EXP_GAP);
        chk("pace_rd2_req", rtc_rd_req, 1);
        chk("pace_rd_done_low", rd_done, 0);
        tick();
        rtc_rd_ack = 1'b1;
        tick();
        rtc_rd_ack = 1'b0;
        chk("pace_rd2_done", rd_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
